// File: rtl/mux_reg_pkg.sv
// Shared width helpers for the muxed register pipeline.
// Widths never collapse to zero, even for the smallest legal parameters.
package mux_reg_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sel_w(input int num_in);
        return clog2_min1(num_in);
    endfunction

    function automatic int occ_w(input int depth);
        return clog2_min1(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One {valid, data} register of the elastic pipeline.
// Flush clears only the valid bit; the data is left as it is.
module pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             move,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (move) begin
            valid <= load_valid;
            if (load_valid) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/mux_reg_pipe.sv
// NUM_IN:1 word select feeding a DEPTH-stage valid/ready register pipeline,
// with flush, occupancy count and an out-of-range select flag.
module mux_reg_pipe
    import mux_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               NUM_IN    = 4,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*WIDTH-1:0]   d,
    input  logic [sel_w(NUM_IN)-1:0]  sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [occ_w(DEPTH)-1:0]   occupancy,
    output logic                      sel_err
);

    localparam int SEL_W = sel_w(NUM_IN);
    localparam int OCC_W = occ_w(DEPTH);
    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] mv;
    logic [WIDTH-1:0] data [DEPTH];
    logic [WIDTH-1:0] word;
    logic             sel_oor;
    logic             accept;
    logic             retire;

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                word = d[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_oor = ({1'b0, sel} >= NUM_IN_L);

    // Ready ripples back from the output: a stage moves once any later
    // stage has a hole or the consumer takes the head word.
    always_comb begin
        logic go;
        go = out_ready | ~v[DEPTH-1];
        mv = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            mv[k] = go;
            if (k > 0) begin
                go = go | ~v[k];
            end
        end
    end

    assign in_ready  = mv[0] & ~flush;
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;
    assign q         = data[DEPTH-1];
    assign out_valid = v[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             ld_v;
        logic [WIDTH-1:0] ld_d;
        if (k == 0) begin : g_head
            assign ld_v = accept;
            assign ld_d = word;
        end else begin : g_body
            assign ld_v = v[k-1];
            assign ld_d = data[k-1];
        end
        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .move       (mv[k]),
            .load_valid (ld_v),
            .load_data  (ld_d),
            .valid      (v[k]),
            .data       (data[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
            sel_err   <= 1'b0;
        end else if (flush) begin
            occupancy <= '0;
            sel_err   <= 1'b0;
        end else begin
            occupancy <= occupancy + OCC_W'(accept) - OCC_W'(retire);
            sel_err   <= accept & sel_oor;
        end
    end

endmodule

// File: doc/mux_reg_pipe.md
Name: mux_reg_pipe

Overview:
- Parametrised successor to the team's single-bit 2:1 muxed D flip-flop with synchronous reset.
- Selects one of NUM_IN words, each WIDTH bits wide, and carries the selected word through a DEPTH-stage elastic register pipeline under valid/ready flow control.
- Adds a synchronous flush, an occupancy count and a select-range error flag.
- Used as a generic registered select/retime stage between datapath blocks that can apply backpressure.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- NUM_IN, 4: number of selectable input words (>=2).
- DEPTH, 3: number of pipeline register stages (>=1).
- RESET_VAL, 0: WIDTH-bit value loaded into every data stage on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- d  input  NUM_IN*WIDTH  input words; word i occupies bits [i*WIDTH +: WIDTH].
- sel  input  $clog2(NUM_IN)  index of the word to capture.
- in_valid  input  1  upstream offers the selected word this cycle.
- in_ready  output  1  pipeline accepts the word this cycle.
- flush  input  1  synchronous discard of all in-flight words.
- q  output  WIDTH  data of the last stage.
- out_valid  output  1  q holds a valid word.
- out_ready  input  1  downstream accepts q this cycle.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.
- sel_err  output  1  one-cycle pulse on an accepted word with sel >= NUM_IN.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - All stage valid bits = 0, so out_valid = 0.
  - All stage data = RESET_VAL, so q = RESET_VAL.
  - occupancy = 0, sel_err = 0, in_ready = 1 in the cycle after reset.
- Stage k, for k = 0..DEPTH-1, holds the pair {v[k], data[k]}. Stage DEPTH-1 drives q and out_valid.
- Advance rule:
  - The last stage moves if out_ready = 1 or v[DEPTH-1] = 0.
  - Stage k moves if stage k+1 moves or v[k+1] = 0.
  - This is combinational ready propagation, so a full pipeline with out_ready held high sustains 1 word/cycle.
- in_ready = 1 when stage 0 moves.
- A word is accepted when in_valid and in_ready are both 1. On acceptance, stage 0 loads d[sel*WIDTH +: WIDTH] and v[0] becomes 1. If stage 0 moves without an acceptance, v[0] becomes 0.
- Latency: an accepted word appears on q with out_valid = 1 exactly DEPTH cycles after acceptance when no backpressure occurs. Each cycle of backpressure adds one cycle.
- Holding:
  - A stage that does not move keeps its data and valid bit unchanged.
  - q is stable while out_valid = 1 and out_ready = 0.
  - Data of invalid stages is don't-care to consumers but must not become X.
- Out-of-range select (possible only when NUM_IN is not a power of two):
  - An accepted word with sel >= NUM_IN loads data 0 with v[0] = 1.
  - sel_err is 1 in the following cycle only.
  - sel_err never fires on a cycle without acceptance.
- Flush:
  - All v[k] = 0 on the next edge.
  - Data registers are left unchanged.
  - Any word offered in the flush cycle is dropped: in_ready is forced to 0 while flush = 1.
  - occupancy = 0 after the flush edge.
- Occupancy: registered popcount of v[], updated every cycle. When a word is accepted and another retired in the same cycle, the count is unchanged.
- Priority of simultaneous events: rst > flush > normal advance.
- Reset asserted mid-stream: all in-flight words are lost and the reset values apply on the next edge, regardless of in_valid, out_ready or flush.
- DEPTH = 1: the block degenerates to a muxed register with a valid/ready handshake, and the same rules apply.

Decomposition:
- Shared package mux_reg_pkg holds:
  - the function clog2_min1, which returns at least 1 so the sel and occupancy ports are never zero-width;
  - the localparam formulas for SEL_W and OCC_W.
- One sub-module is natural: pipe_stage, a single {valid, data} register with a move input, a load input and synchronous reset/flush. mux_reg_pipe instantiates DEPTH of these in a generate loop, plus the input mux, the ready chain and the occupancy counter.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in_valid = 1 and d = all-ones -> out_valid = 0, q = RESET_VAL (0x00), occupancy = 0, in_ready = 1 after release.
- Streaming (WIDTH = 8, NUM_IN = 4, DEPTH = 3): out_ready = 1; words 0x11, 0x22, 0x33, 0x44 on inputs 0..3; sel = 0,1,2,3 on consecutive cycles -> q = 0x11, 0x22, 0x33, 0x44 on cycles 3..6 after the first acceptance; occupancy reaches 3.
- Backpressure: pipeline full, out_ready = 0 for 4 cycles -> in_ready = 0, q holds 0x11, occupancy = 3. Release -> remaining words drain in order with none lost or duplicated.
- Flush: pipeline full, assert flush for 1 cycle with in_valid = 1 -> that word is not accepted; out_valid = 0 and occupancy = 0 next cycle; the next accepted word emerges after exactly 3 cycles.
- Select error (NUM_IN = 3): accept a word with sel = 3 -> sel_err pulses for exactly 1 cycle and that word exits with q = 0x00. With sel = 3 and in_valid = 0 -> no pulse.
- Mid-stream reset: rst asserted while 2 words are in flight and out_ready = 0 -> next cycle out_valid = 0, occupancy = 0, and neither word ever appears on q.
